// File: rtl/trv32i_halt_monitor.sv
// End-of-test monitor for TRV32I: watches the fetch stream for ECALL, illegal
// opcodes, a stuck PC or a global timeout, drains, then latches a sticky status.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | watching pc/inst for a terminating event, counting cycles
// ST_DRAIN | event captured, counting down the drain window, inputs ignored
// ST_DONE  | status latched; left only through rst or clr
module trv32i_halt_monitor #(
    parameter int                XLEN           = 32,
    parameter logic [XLEN-1:0]   END_INST       = XLEN'(32'h0000_0073),
    parameter int                DRAIN_CYCLES   = 4,
    parameter int                HANG_CYCLES    = 64,
    parameter int                TIMEOUT_CYCLES = 100000,
    parameter int                CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  inst,
    input  logic             inst_valid,
    input  logic             clr,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [XLEN-1:0]  halt_pc,
    output logic [XLEN-1:0]  halt_inst,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [1:0]       CAUSE_END     = 2'd0;
    localparam logic [1:0]       CAUSE_TIMEOUT = 2'd1;
    localparam logic [1:0]       CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0]       CAUSE_HANG    = 2'd3;
    localparam logic [31:0]      HANG_LAST     = 32'(HANG_CYCLES - 1);
    localparam logic [31:0]      DRAIN_LOAD    = 32'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [XLEN-1:0]   prev_pc;
    logic [XLEN-1:0]   prev_inst;
    logic              prev_valid;
    logic [31:0]       hang_cnt;
    logic [31:0]       drain_cnt;
    logic [1:0]        cause;

    logic              opcode_ok;
    logic              pc_same;
    logic              end_hit;
    logic              ill_hit;
    logic              hang_hit;
    logic              tmo_hit;
    logic              det;
    logic [1:0]        det_cause;
    logic [XLEN-1:0]   cap_pc;
    logic [XLEN-1:0]   cap_inst;
    logic              cnt_sat;

    always_comb begin
        opcode_ok = 1'b0;
        case (inst[6:2])
            5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
            5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100: opcode_ok = 1'b1;
            default:                                         opcode_ok = 1'b0;
        endcase
    end

    assign pc_same  = prev_valid && (pc == prev_pc);
    assign end_hit  = inst_valid && (inst == END_INST);
    assign ill_hit  = inst_valid && ((inst[1:0] != 2'b11) || !opcode_ok);
    assign hang_hit = (HANG_CYCLES != 0) && inst_valid && pc_same && (hang_cnt == HANG_LAST);
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cycle_count == TMO_LAST);
    assign det      = end_hit || ill_hit || hang_hit || tmo_hit;
    assign cnt_sat  = &cycle_count;

    always_comb begin
        det_cause = CAUSE_TIMEOUT;
        if (end_hit)
            det_cause = CAUSE_END;
        else if (ill_hit)
            det_cause = CAUSE_ILLEGAL;
        else if (hang_hit)
            det_cause = CAUSE_HANG;
    end

    // A timeout on an idle cycle reports the last instruction actually fetched.
    assign cap_pc   = inst_valid ? pc   : prev_pc;
    assign cap_inst = inst_valid ? inst : prev_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            prev_pc     <= '0;
            prev_inst   <= '0;
            prev_valid  <= 1'b0;
            hang_cnt    <= '0;
            drain_cnt   <= '0;
            cause       <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= '0;
            halt_pc     <= '0;
            halt_inst   <= '0;
            cycle_count <= '0;
        end else if (clr) begin
            state       <= ST_RUN;
            prev_pc     <= '0;
            prev_inst   <= '0;
            prev_valid  <= 1'b0;
            hang_cnt    <= '0;
            drain_cnt   <= '0;
            cause       <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= '0;
            halt_pc     <= '0;
            halt_inst   <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!cnt_sat)
                        cycle_count <= cycle_count + 1'b1;
                    if (inst_valid) begin
                        prev_pc    <= pc;
                        prev_inst  <= inst;
                        prev_valid <= 1'b1;
                        hang_cnt   <= pc_same ? hang_cnt + 32'd1 : 32'd0;
                    end
                    if (det) begin
                        halt_pc   <= cap_pc;
                        halt_inst <= cap_inst;
                        cause     <= det_cause;
                        if (DRAIN_CYCLES == 0) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            pass      <= (det_cause == CAUSE_END);
                            fail_code <= det_cause;
                        end else begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!cnt_sat)
                        cycle_count <= cycle_count + 1'b1;
                    if (drain_cnt == 32'd0) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        pass      <= (cause == CAUSE_END);
                        fail_code <= cause;
                    end else begin
                        drain_cnt <= drain_cnt - 32'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_trv32i_halt_monitor.sv
// Randomised and directed bench for trv32i_halt_monitor; two instances with
// different parameters share one input stream and a behavioural reference model.
module tb_trv32i_halt_monitor;

    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] ADDI  = 32'h0000_0013;
    localparam logic [31:0] JAL   = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic        clr = 1'b0;

    logic        done_w [2];
    logic        pass_w [2];
    logic [1:0]  fc_w   [2];
    logic [31:0] hpc_w  [2];
    logic [31:0] hin_w  [2];
    logic [31:0] cc_a;
    logic [7:0]  cc_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    trv32i_halt_monitor #(.DRAIN_CYCLES(4), .HANG_CYCLES(8), .TIMEOUT_CYCLES(50), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .inst_valid(inst_valid), .clr(clr),
        .done(done_w[0]), .pass(pass_w[0]), .fail_code(fc_w[0]),
        .halt_pc(hpc_w[0]), .halt_inst(hin_w[0]), .cycle_count(cc_a));

    trv32i_halt_monitor #(.DRAIN_CYCLES(0), .HANG_CYCLES(0), .TIMEOUT_CYCLES(0), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .inst_valid(inst_valid), .clr(clr),
        .done(done_w[1]), .pass(pass_w[1]), .fail_code(fc_w[1]),
        .halt_pc(hpc_w[1]), .halt_inst(hin_w[1]), .cycle_count(cc_b));

    // reference model: per-instance parameters and observed history
    int      p_drain [2] = '{4, 0};
    int      p_hang  [2] = '{8, 0};
    int      p_tmo   [2] = '{50, 0};
    longint  p_max   [2] = '{64'hFFFF_FFFF, 64'd255};

    longint      m_edges [2];
    bit          m_det   [2];
    bit          m_done  [2];
    int          m_since [2];
    int          m_cause [2];
    logic [31:0] m_hpc   [2];
    logic [31:0] m_hin   [2];
    logic [31:0] m_lpc   [2];
    logic [31:0] m_lin   [2];
    bit          m_have  [2];
    int          m_run   [2];

    logic [6:0] legal_ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                   7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    function automatic bit is_legal(input logic [31:0] x);
        logic [6:0] op;
        op = x[6:0];
        return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                          7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_edges[i] = 0; m_det[i] = 0; m_done[i] = 0; m_since[i] = 0;
            m_cause[i] = 0; m_hpc[i] = '0; m_hin[i] = '0; m_lpc[i] = '0;
            m_lin[i] = '0; m_have[i] = 0; m_run[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input logic [31:0] p, input logic [31:0] ins, input logic v);
        int  c;
        bit  eq;
        int  nrun;
        if (m_done[i]) return;
        if (m_edges[i] < p_max[i]) m_edges[i]++;
        if (m_det[i]) begin
            m_since[i]++;
            if (m_since[i] == p_drain[i]) m_done[i] = 1;
            return;
        end
        c = -1;
        if (v) begin
            eq   = m_have[i] && (p == m_lpc[i]);
            nrun = eq ? m_run[i] + 1 : 0;
            if (ins == ECALL)                                c = 0;
            else if (!is_legal(ins))                         c = 2;
            else if (p_hang[i] > 0 && eq && nrun == p_hang[i]) c = 3;
            m_run[i] = nrun; m_lpc[i] = p; m_lin[i] = ins; m_have[i] = 1;
        end
        if (c < 0 && p_tmo[i] > 0 && m_edges[i] == p_tmo[i]) c = 1;
        if (c >= 0) begin
            m_det[i] = 1; m_cause[i] = c; m_hpc[i] = m_lpc[i]; m_hin[i] = m_lin[i];
            m_since[i] = 0;
            if (p_drain[i] == 0) m_done[i] = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("done%0d", i), done_w[i], m_done[i]);
            chk($sformatf("pass%0d", i), pass_w[i], m_done[i] && m_cause[i] == 0);
            chk($sformatf("fail_code%0d", i), fc_w[i], m_done[i] ? m_cause[i] : 0);
            chk($sformatf("halt_pc%0d", i), hpc_w[i], m_det[i] ? m_hpc[i] : 32'h0);
            chk($sformatf("halt_inst%0d", i), hin_w[i], m_det[i] ? m_hin[i] : 32'h0);
        end
        chk("cycle_count0", cc_a, m_edges[0]);
        chk("cycle_count1", cc_b, m_edges[1]);
    endtask

    // drive at negedge, model at posedge, compare at the following negedge
    task automatic step(input logic [31:0] p, input logic [31:0] ins, input logic v, input logic c);
        pc = p; inst = ins; inst_valid = v; clr = c;
        @(posedge clk);
        if (rst || c) model_reset();
        else for (int i = 0; i < 2; i++) model_step(i, p, ins, v);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], legal_ops[$urandom_range(10, 0)]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lv;
        logic [31:0] rp;
        int          nv;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // ECALL at pc 0x40 on edge 20
        for (int k = 1; k <= 24; k++) begin
            step(32'h40 - 32'(4 * (20 - k)), (k == 20) ? ECALL : ADDI, 1'b1, 1'b0);
            if (k == 20) chk("end_hpc", hpc_w[0], 32'h40);
            if (k == 23) chk("end_early", done_w[0], 1'b0);
        end
        chk("end_done", done_w[0], 1'b1);
        chk("end_pass", pass_w[0], 1'b1);
        chk("end_fc", fc_w[0], 2'd0);
        chk("end_cc", cc_a, 32'd24);

        step(32'h0, ADDI, 1'b0, 1'b1);
        chk("clr_done", done_w[0], 1'b0);
        chk("clr_cc", cc_a, 32'd0);

        // illegal opcode, then an ECALL during the drain window
        for (int k = 1; k <= 3; k++) step(32'(4 * k), ADDI, 1'b1, 1'b0);
        step(32'h10, 32'h0, 1'b1, 1'b0);
        step(32'h14, ECALL, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(32'h18 + 32'(4 * k), ADDI, 1'b1, 1'b0);
        chk("ill_done", done_w[0], 1'b1);
        chk("ill_fc", fc_w[0], 2'd2);
        chk("ill_pass", pass_w[0], 1'b0);
        chk("ill_hinst", hin_w[0], 32'h0);
        chk("ill_hpc", hpc_w[0], 32'h10);

        // hang at pc 0x20 with gaps in inst_valid
        step(32'h0, ADDI, 1'b0, 1'b1);
        nv = 0;
        for (int k = 1; k < 40 && nv < 9; k++) begin
            step(32'h20, JAL, (k % 3) != 0, 1'b0);
            if ((k % 3) != 0) begin
                nv++;
                if (nv == 8) chk("hang_early", hpc_w[0], 32'h0);
            end
        end
        chk("hang_hpc", hpc_w[0], 32'h20);
        chk("hang_hinst", hin_w[0], JAL);
        repeat (4) step(32'h20, JAL, 1'b1, 1'b0);
        chk("hang_fc", fc_w[0], 2'd3);

        // ECALL landing exactly on the hang threshold
        step(32'h0, ADDI, 1'b0, 1'b1);
        repeat (8) step(32'h80, JAL, 1'b1, 1'b0);
        step(32'h80, ECALL, 1'b1, 1'b0);
        chk("prio_hinst", hin_w[0], ECALL);
        repeat (4) step(32'h84, ADDI, 1'b1, 1'b0);
        chk("prio_fc", fc_w[0], 2'd0);
        chk("prio_pass", pass_w[0], 1'b1);

        // clr coincident with a detection
        step(32'h0, ADDI, 1'b0, 1'b1);
        step(32'h100, ECALL, 1'b1, 1'b1);
        chk("clrdet_hpc", hpc_w[0], 32'h0);
        chk("clrdet_done", done_w[1], 1'b0);

        // timeout at edge 50 on an idle cycle; instance b never times out
        step(32'h0, ADDI, 1'b0, 1'b1);
        lv = '0;
        for (int k = 1; k <= 1000; k++) begin
            logic v;
            v = (k == 50) ? 1'b0 : (k == 49) ? 1'b1 : ($urandom_range(3, 0) != 0);
            if (v && k < 50) lv = 32'h200 + 32'(4 * k);
            step(32'h200 + 32'(4 * k), ADDI, v, 1'b0);
            if (k == 49) chk("tmo_early", hpc_w[0], 32'h0);
            if (k == 50) chk("tmo_hpc", hpc_w[0], lv);
            if (k == 53) chk("tmo_early_done", done_w[0], 1'b0);
            if (k == 54) chk("tmo_fc", fc_w[0], 2'd1);
        end
        chk("tmo_cc_frozen", cc_a, 32'd54);
        chk("tmo0_done", done_w[1], 1'b0);
        chk("tmo0_sat", cc_b, 8'hFF);

        // asynchronous rst in the middle of the drain window
        step(32'h0, ADDI, 1'b0, 1'b1);
        step(32'h300, ECALL, 1'b1, 1'b0);
        step(32'h304, ADDI, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_hpc", hpc_w[0], 32'h0);
        chk("arst_cc", cc_a, 32'h0);
        chk("arst_done", done_w[1], 1'b0);
        model_reset();
        @(negedge clk);
        step(32'h0, ADDI, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) step(32'h400 + 32'(4 * k), (k == 3) ? ECALL : ADDI, 1'b1, 1'b0);
        chk("arst_restart", fc_w[0], 2'd0);

        // randomized streams
        for (int t = 0; t < 30; t++) begin
            int hold_pct;
            step(32'h0, ADDI, 1'b0, 1'b1);
            hold_pct = $urandom_range(90, 10);
            rp = $urandom & 32'hFFFF_FFFC;
            for (int k = 0; k < 120; k++) begin
                logic [31:0] ins;
                int          r;
                if ($urandom_range(99, 0) >= hold_pct) rp = rp + 32'd4;
                r = $urandom_range(99, 0);
                if (r < 3)      ins = ECALL;
                else if (r < 6) ins = $urandom;
                else            ins = rand_legal();
                step(rp, ins, $urandom_range(3, 0) != 0, $urandom_range(99, 0) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
